// File: rtl/apb_master_bridge.sv
// Command/response to APB master bridge: one transfer at a time, optional one-cycle
// registered read-data latency on the requester, and an ACCESS wait-state timeout.
module apb_master_bridge #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned RDATA_LAT = 1,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  typedef enum logic [2:0] {StIdle, StSetup, StAccess, StRdWait, StResp} state_e;

  // The abort fires on the ACCESS cycle whose wait increment makes the count reach TIMEOUT.
  localparam logic [7:0] WaitLast = 8'(TIMEOUT - 1);

  state_e            state_q;
  logic [7:0]        wait_q;
  logic              cmd_ready_q;
  logic              psel_q;
  logic              penable_q;
  logic              pwrite_q;
  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q;
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q     <= StIdle;
      wait_q      <= '0;
      cmd_ready_q <= 1'b1;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rdata_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cmd_valid && cmd_ready_q) begin
            state_q     <= StSetup;
            cmd_ready_q <= 1'b0;
            psel_q      <= 1'b1;
            pwrite_q    <= cmd_write;
            paddr_q     <= cmd_addr;
            pwdata_q    <= cmd_wdata;
          end
        end
        StSetup: begin
          state_q   <= StAccess;
          penable_q <= 1'b1;
          wait_q    <= '0;
        end
        StAccess: begin
          if (pready) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            rsp_err_q <= pslverr;
            if (!pwrite_q && RDATA_LAT != 0) begin
              state_q <= StRdWait;
            end else begin
              state_q     <= StResp;
              rsp_valid_q <= 1'b1;
              rdata_q     <= (pwrite_q || pslverr) ? '0 : prdata;
            end
          end else begin
            wait_q <= wait_q + 8'd1;
            if (wait_q == WaitLast) begin
              state_q     <= StResp;
              psel_q      <= 1'b0;
              penable_q   <= 1'b0;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rdata_q     <= '0;
            end
          end
        end
        StRdWait: begin
          // Errored reads still spend this cycle, but their data is dropped.
          state_q     <= StResp;
          rsp_valid_q <= 1'b1;
          rdata_q     <= rsp_err_q ? '0 : prdata;
        end
        StResp: begin
          if (rsp_ready) begin
            state_q     <= StIdle;
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= StIdle;
          cmd_ready_q <= 1'b1;
          psel_q      <= 1'b0;
          penable_q   <= 1'b0;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = rsp_err_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign psel      = psel_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;

endmodule

// File: doc/apb_master_bridge.md
APB_MASTER_BRIDGE -- requirements
Module: apb_master_bridge

Interface
REQ-001 Parameter: ADDR_W, default 32, width of paddr and cmd_addr.
REQ-002 Parameter: DATA_W, default 32, width of pwdata, prdata, cmd_wdata and rsp_rdata.
REQ-003 Parameter: RDATA_LAT, default 1, requester read-data latency in cycles after the completing ACCESS cycle; legal values 0 or 1.
REQ-004 Parameter: TIMEOUT, default 16, maximum ACCESS cycles with pready low before the bridge aborts; legal range 1..255.
REQ-005 Port list (name, direction, width, meaning), one port per line:
- pclk  in  1  single clock; all logic is on the rising edge.
- preset  in  1  reset; synchronous and active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  bridge accepts a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  target address.
- cmd_wdata  in  DATA_W  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumer accepts.
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors.
- rsp_err  out  1  pslverr or timeout occurred.
- paddr  out  ADDR_W  APB address.
- pwdata  out  DATA_W  APB write data.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- prdata  in  DATA_W  APB read data.
- pready  in  1  APB ready; tie high for requesters without wait states.
- pslverr  in  1  APB error; sampled only when pready is high in ACCESS.

Function
REQ-006 The FSM SHALL have the states IDLE, SETUP, ACCESS, RDWAIT and RESP, all registered.
REQ-007 cmd_ready SHALL be 1 only in IDLE; a command is accepted when cmd_valid and cmd_ready are both 1 on a clock edge.
REQ-008 On acceptance, the bridge SHALL latch cmd_write, cmd_addr and cmd_wdata into paddr, pwrite and pwdata, and SHALL enter SETUP.
REQ-009 In SETUP: psel=1, penable=0 for exactly one cycle, then the FSM goes to ACCESS.
REQ-010 In ACCESS: psel=1, penable=1; paddr, pwrite and pwdata SHALL stay stable until ACCESS is left.
REQ-011 In ACCESS with pready=1, the transfer completes; rsp_err is set to pslverr.
- Write, or read with RDATA_LAT=0: prdata is captured (reads only) and the FSM goes to RESP.
- Read with RDATA_LAT=1: the FSM goes to RDWAIT.
REQ-012 In RDWAIT: psel=0, penable=0; prdata SHALL be captured at the end of this single cycle, then the FSM goes to RESP.
REQ-013 A wait counter SHALL clear on entry to ACCESS and increment each ACCESS cycle with pready=0.
REQ-014 When the wait counter reaches TIMEOUT, the bridge SHALL drop psel/penable, set rsp_err=1 and rsp_rdata=0, and go to RESP.
REQ-015 In RESP: rsp_valid=1, psel=0, penable=0; rsp_rdata and rsp_err SHALL be held stable until rsp_ready=1, then the FSM returns to IDLE.
REQ-016 rsp_rdata SHALL be 0 for writes and for any errored transfer; on a pslverr read, captured data SHALL be discarded.
REQ-017 A command presented in RESP or in any busy state SHALL NOT be accepted; back-to-back transfers require at least one IDLE cycle.
REQ-018 Latency from acceptance edge (cycle 0) to rsp_valid SHALL be:
- write, or read with RDATA_LAT=0: cycle 3 plus wait cycles.
- read with RDATA_LAT=1: cycle 4 plus wait cycles.
REQ-019 psel and penable SHALL never both be 1 outside ACCESS, and penable SHALL never be 1 while psel is 0.

Reset
REQ-020 While preset=1 at a clock edge, the FSM SHALL go to IDLE, with these outputs forced to 0: psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err; cmd_ready SHALL be 1 from the following cycle.
REQ-021 preset asserted mid-transfer (SETUP, ACCESS, RDWAIT or RESP) SHALL abort the transfer with no response issued; any pending rsp_valid SHALL drop.
REQ-022 The wait counter and the captured read data register SHALL clear to 0 on reset.

Verification
REQ-023 Bench SHALL cover these directed scenarios:
- Write, against the team APB register slave (pready tied 1, RDATA_LAT=1): cmd write addr 0x8 data 0xDEADBEEF -> psel cycle 1, penable cycle 2, rsp_valid cycle 3, rsp_err=0; a subsequent read of 0x8 returns 0xDEADBEEF.
- Read after requester reset, same setup: read addr 0x4 -> rsp_valid cycle 4, rsp_rdata=0x5A5A5555; read addr 0x10 -> 0x0000FFFF.
- Wait states (RDATA_LAT=0): pready low 3 ACCESS cycles, prdata=0x12349876 -> rsp_valid cycle 6, data 0x12349876, address stable throughout.
- Timeout (TIMEOUT=4, pready held 0): -> exactly 4 ACCESS cycles, then rsp_valid with rsp_err=1, rsp_rdata=0.
- pslverr=1 on read completion -> rsp_err=1, rsp_rdata=0; response held 5 cycles under rsp_ready=0, unchanged.
- preset pulsed during ACCESS -> psel=penable=0 next cycle, no rsp_valid, cmd_ready=1 the cycle after reset deasserts.
